// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
// Shared definitions for the BNN layer sequencer:
//   - top-level FSM state encodings (the sequencer decodes these to start layers)
//   - layer geometry (neurons per layer, weight words per neuron)
//   - weight-memory layer base addresses, fixed at elaboration time
//   - internal sequencer state enum
//   - helper functions mapping a layer id to its base address / loop bounds
// -----------------------------------------------------------------------------
package bnn_pkg;

    localparam int WORD_W       = 32;   // bits per weight word / accumulate step
    localparam int ADDR_W       = 12;   // weight memory address width

    localparam int L1_NEURONS   = 128;
    localparam int L1_WORDS     = 25;   // 784 input pixels packed into 32-bit words
    localparam int L2_NEURONS   = 64;
    localparam int L2_WORDS     = 4;
    localparam int L3_NEURONS   = 10;
    localparam int L3_WORDS     = 2;

    localparam int WORD_IDX_W   = 5;    // holds L1_WORDS-1
    localparam int NEURON_IDX_W = 7;    // holds L1_NEURONS-1

    // Weights are stored layer after layer, neuron-major, so each layer's
    // region starts right after the previous one.
    localparam int L1_BASE = 0;
    localparam int L2_BASE = L1_BASE + L1_NEURONS * L1_WORDS;
    localparam int L3_BASE = L2_BASE + L2_NEURONS * L2_WORDS;

    // Top-level FSM states, shared with the top FSM.
    typedef enum logic [2:0] {
        TOP_IDLE = 3'b000,
        TOP_LOAD = 3'b001,
        TOP_L1   = 3'b010,
        TOP_L2   = 3'b011,
        TOP_L3   = 3'b100
    } top_state_e;

    // Sequencer-internal states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_ACC    = 3'd2,
        S_COMMIT = 3'd3,
        S_DONE   = 3'd4,
        S_WAIT   = 3'd5
    } seq_state_e;

    function automatic logic is_layer_state(input logic [2:0] s);
        return (s == TOP_L1) || (s == TOP_L2) || (s == TOP_L3);
    endfunction

    function automatic logic [ADDR_W-1:0] layer_base(input logic [2:0] layer);
        case (layer)
            TOP_L2:  return ADDR_W'(L2_BASE);
            TOP_L3:  return ADDR_W'(L3_BASE);
            default: return ADDR_W'(L1_BASE);
        endcase
    endfunction

    function automatic logic [WORD_IDX_W-1:0] layer_last_word(input logic [2:0] layer);
        case (layer)
            TOP_L2:  return WORD_IDX_W'(L2_WORDS - 1);
            TOP_L3:  return WORD_IDX_W'(L3_WORDS - 1);
            default: return WORD_IDX_W'(L1_WORDS - 1);
        endcase
    endfunction

    function automatic logic [NEURON_IDX_W-1:0] layer_last_neuron(input logic [2:0] layer);
        case (layer)
            TOP_L2:  return NEURON_IDX_W'(L2_NEURONS - 1);
            TOP_L3:  return NEURON_IDX_W'(L3_NEURONS - 1);
            default: return NEURON_IDX_W'(L1_NEURONS - 1);
        endcase
    endfunction

endpackage

// File: rtl/bnn_loop_ctr.sv
// -----------------------------------------------------------------------------
// bnn_loop_ctr
// Nested word/neuron loop counter for the layer sequencer. Loaded with the
// last word index and last neuron index of a layer, then stepped by the
// sequencer. Flags report when the current indices hit those bounds.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_load           restart both counters at 0 and capture new bounds
//   i_last_word      last word index of the layer being loaded
//   i_last_neuron    last neuron index of the layer being loaded
//   i_word_inc       advance to next word of the current neuron
//   i_neuron_inc     advance to next neuron (word index returns to 0)
//   o_word_idx       current word index
//   o_neuron_idx     current neuron index
//   o_last_word      current word is the last one of the neuron
//   o_last_neuron    current neuron is the last one of the layer
// -----------------------------------------------------------------------------
module bnn_loop_ctr
    import bnn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic [WORD_IDX_W-1:0]   i_last_word,
    input  logic [NEURON_IDX_W-1:0] i_last_neuron,
    input  logic                    i_word_inc,
    input  logic                    i_neuron_inc,
    output logic [WORD_IDX_W-1:0]   o_word_idx,
    output logic [NEURON_IDX_W-1:0] o_neuron_idx,
    output logic                    o_last_word,
    output logic                    o_last_neuron
);

    logic [WORD_IDX_W-1:0]   r_word_idx;
    logic [NEURON_IDX_W-1:0] r_neuron_idx;
    logic [WORD_IDX_W-1:0]   r_last_word;
    logic [NEURON_IDX_W-1:0] r_last_neuron;

    // Neuron step takes priority over word step: moving to a new neuron
    // always restarts its word loop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_idx    <= '0;
            r_neuron_idx  <= '0;
            r_last_word   <= '0;
            r_last_neuron <= '0;
        end else if (i_load) begin
            r_word_idx    <= '0;
            r_neuron_idx  <= '0;
            r_last_word   <= i_last_word;
            r_last_neuron <= i_last_neuron;
        end else if (i_neuron_inc) begin
            r_word_idx    <= '0;
            r_neuron_idx  <= r_neuron_idx + NEURON_IDX_W'(1);
        end else if (i_word_inc) begin
            r_word_idx    <= r_word_idx + WORD_IDX_W'(1);
        end
    end

    assign o_word_idx    = r_word_idx;
    assign o_neuron_idx  = r_neuron_idx;
    assign o_last_word   = (r_word_idx == r_last_word);
    assign o_last_neuron = (r_neuron_idx == r_last_neuron);

endmodule

// File: rtl/bnn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// bnn_layer_sequencer
// Sequences the XNOR-popcount datapath through one BNN layer each time the
// top-level FSM enters LAYER_1/2/3. For every output neuron it fetches each
// weight word over a req/valid handshake, pulses the accumulator, then
// commits the neuron's output bit. A one-cycle done pulse per layer advances
// the top-level FSM.
//
// Optional feature macro: BNN_SEQ_PERF_EN adds o_perf_stall_cnt, counting
// cycles where a fetch request waits on memory (cleared at layer start,
// saturating).
//
// Ports:
//   clk               clock
//   rst_n             asynchronous active-low reset
//   i_state           top FSM state (000 IDLE, 001 LOAD, 010 L1, 011 L2, 100 L3)
//   o_w_req           weight fetch request, held until accepted
//   o_w_addr          weight word address, stable while o_w_req is high
//   i_w_valid         memory returns word; handshake on o_w_req && i_w_valid
//   o_mac_en          one-cycle pulse: accumulate popcount of returned word
//   o_mac_first       with o_mac_en: word 0 of the neuron (load, not add)
//   o_neuron_commit   one-cycle pulse: threshold accumulator, write bit
//   o_out_idx         current output neuron index
//   o_layer_1_done    one-cycle pulse when layer 1 completes
//   o_layer_2_done    one-cycle pulse when layer 2 completes
//   o_layer_3_done    one-cycle pulse when layer 3 completes
//   o_perf_stall_cnt  (BNN_SEQ_PERF_EN only) request-stall cycle count
// -----------------------------------------------------------------------------
module bnn_layer_sequencer
    import bnn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              i_state,
    output logic                    o_w_req,
    output logic [ADDR_W-1:0]       o_w_addr,
    input  logic                    i_w_valid,
    output logic                    o_mac_en,
    output logic                    o_mac_first,
    output logic                    o_neuron_commit,
    output logic [NEURON_IDX_W-1:0] o_out_idx,
`ifdef BNN_SEQ_PERF_EN
    output logic [31:0]             o_perf_stall_cnt,
`endif
    output logic                    o_layer_1_done,
    output logic                    o_layer_2_done,
    output logic                    o_layer_3_done
);

    seq_state_e r_state;
    seq_state_e w_state_next;

    logic [2:0]              r_layer;
    logic [ADDR_W-1:0]       r_w_addr;

    logic                    w_start;
    logic                    w_abort;
    logic                    w_addr_inc;
    logic                    w_word_inc;
    logic                    w_neuron_inc;

    logic [WORD_IDX_W-1:0]   w_word_idx;
    logic [NEURON_IDX_W-1:0] w_neuron_idx;
    logic                    w_last_word;
    logic                    w_last_neuron;
    logic [2:0]              w_done_vec;

    // The top FSM leaving the latched layer cancels the run. In S_WAIT the
    // same condition is what releases the sequencer for the next layer.
    assign w_abort = (i_state != r_layer);

    // ---------------------------------------------------------------------
    // Loop counters
    // ---------------------------------------------------------------------
    bnn_loop_ctr u_loop_ctr (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (w_start),
        .i_last_word   (layer_last_word(i_state)),
        .i_last_neuron (layer_last_neuron(i_state)),
        .i_word_inc    (w_word_inc),
        .i_neuron_inc  (w_neuron_inc),
        .o_word_idx    (w_word_idx),
        .o_neuron_idx  (w_neuron_idx),
        .o_last_word   (w_last_word),
        .o_last_neuron (w_last_neuron)
    );

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------------
    // Latched layer and running weight address. Weights are laid out
    // neuron-major and contiguous per layer, so a simple increment after each
    // consumed word walks the whole layer.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_layer  <= TOP_IDLE;
            r_w_addr <= '0;
        end else if (w_start) begin
            r_layer  <= i_state;
            r_w_addr <= layer_base(i_state);
        end else if (w_addr_inc) begin
            r_w_addr <= r_w_addr + ADDR_W'(1);
        end
    end

    assign o_w_addr  = r_w_addr;
    assign o_out_idx = w_neuron_idx;

    // ---------------------------------------------------------------------
    // Next-state and control decode
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_start         = 1'b0;
        w_addr_inc      = 1'b0;
        w_word_inc      = 1'b0;
        w_neuron_inc    = 1'b0;
        o_w_req         = 1'b0;
        o_mac_en        = 1'b0;
        o_mac_first     = 1'b0;
        o_neuron_commit = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (is_layer_state(i_state)) begin
                    w_start      = 1'b1;
                    w_state_next = S_REQ;
                end
            end

            S_REQ: begin
                o_w_req = 1'b1;
                // Abort wins over a coincident handshake: the word is dropped.
                if (w_abort) begin
                    w_state_next = S_IDLE;
                end else if (i_w_valid) begin
                    w_state_next = S_ACC;
                end
            end

            S_ACC: begin
                o_mac_en    = 1'b1;
                o_mac_first = (w_word_idx == '0);
                if (w_abort) begin
                    w_state_next = S_IDLE;
                end else if (!w_last_word) begin
                    w_word_inc   = 1'b1;
                    w_addr_inc   = 1'b1;
                    w_state_next = S_REQ;
                end else begin
                    w_state_next = S_COMMIT;
                end
            end

            S_COMMIT: begin
                o_neuron_commit = 1'b1;
                if (w_abort) begin
                    w_state_next = S_IDLE;
                end else if (!w_last_neuron) begin
                    w_neuron_inc = 1'b1;
                    w_addr_inc   = 1'b1;
                    w_state_next = S_REQ;
                end else begin
                    w_state_next = S_DONE;
                end
            end

            S_DONE: begin
                w_state_next = S_WAIT;
            end

            S_WAIT: begin
                // Holding here until the top FSM moves on stops a layer from
                // being re-run while its state is still asserted.
                if (w_abort) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Per-layer done pulses. Layer ids L1..L3 are consecutive encodings.
    // ---------------------------------------------------------------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_done
        localparam logic [2:0] LAYER_ID = 3'(int'(TOP_L1) + gi);
        assign w_done_vec[gi] = (r_state == S_DONE) && (r_layer == LAYER_ID);
    end

    assign o_layer_1_done = w_done_vec[0];
    assign o_layer_2_done = w_done_vec[1];
    assign o_layer_3_done = w_done_vec[2];

`ifdef BNN_SEQ_PERF_EN
    // ---------------------------------------------------------------------
    // Memory stall counter: cycles spent requesting without a returned word.
    // ---------------------------------------------------------------------
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall_cnt <= '0;
        end else if (w_start) begin
            r_perf_stall_cnt <= '0;
        end else if (o_w_req && !i_w_valid && (r_perf_stall_cnt != '1)) begin
            r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
        end
    end

    assign o_perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bnn_layer_sequencer
// Self-checking bench for bnn_layer_sequencer. Expected accumulate beats,
// commits and done pulses are queued when a layer is started and popped by a
// negedge monitor as the sequencer produces them. A weight-memory responder in
// the same process answers requests after a programmable delay.
// -----------------------------------------------------------------------------
module tb_bnn_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  state = 3'b000;
    logic        w_valid = 1'b0;

    logic        o_w_req;
    logic [11:0] o_w_addr;
    logic        o_mac_en;
    logic        o_mac_first;
    logic        o_neuron_commit;
    logic [6:0]  o_out_idx;
    logic        o_layer_1_done;
    logic        o_layer_2_done;
    logic        o_layer_3_done;
`ifdef BNN_SEQ_PERF_EN
    logic [31:0] o_perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    bnn_layer_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_state         (state),
        .o_w_req         (o_w_req),
        .o_w_addr        (o_w_addr),
        .i_w_valid       (w_valid),
        .o_mac_en        (o_mac_en),
        .o_mac_first     (o_mac_first),
        .o_neuron_commit (o_neuron_commit),
        .o_out_idx       (o_out_idx),
`ifdef BNN_SEQ_PERF_EN
        .o_perf_stall_cnt(o_perf_stall_cnt),
`endif
        .o_layer_1_done  (o_layer_1_done),
        .o_layer_2_done  (o_layer_2_done),
        .o_layer_3_done  (o_layer_3_done)
    );

    logic [25:0] all_outs;
    assign all_outs = {o_w_req, o_w_addr, o_mac_en, o_mac_first, o_neuron_commit,
                       o_out_idx, o_layer_1_done, o_layer_2_done, o_layer_3_done};

    typedef struct {
        int addr;
        bit first;
        int idx;
    } mac_exp_t;

    mac_exp_t exp_mac_q[$];
    int       exp_commit_q[$];
    int       exp_done_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_mac   = 0;
    int n_commit = 0;
    int n_done[4] = '{0, 0, 0, 0};

    int          resp_delay = 0;
    bit          valid_force = 1'b0;
    int          req_wait = 0;
    bit          prev_req = 1'b0;
    bit          prev_valid = 1'b0;
    logic [11:0] prev_addr = '0;

    // Expected weight layout: neuron-major, layers back to back.
    task automatic push_layer(input int layer);
        int base, neurons, words;
        case (layer)
            2:       begin base = 3200; neurons = 64;  words = 4;  end
            3:       begin base = 3456; neurons = 10;  words = 2;  end
            default: begin base = 0;    neurons = 128; words = 25; end
        endcase
        for (int n = 0; n < neurons; n++) begin
            for (int w = 0; w < words; w++) begin
                exp_mac_q.push_back('{base + n * words + w, (w == 0), n});
            end
            exp_commit_q.push_back(n);
        end
        exp_done_q.push_back(layer);
    endtask

    task automatic flush_expect();
        exp_mac_q.delete();
        exp_commit_q.delete();
        exp_done_q.delete();
    endtask

    // Monitor + memory responder
    initial begin
        mac_exp_t e;
        int       c;
        int       d;
        int       lay;
        forever begin
            @(negedge clk);
            if (o_mac_en) begin
                n_mac++;
                n_tests++;
                if (exp_mac_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mac_unexpected: got mac_en at addr %0d idx %0d, required none", o_w_addr, o_out_idx);
                end else begin
                    e = exp_mac_q.pop_front();
                    if (o_w_addr !== 12'(e.addr) || o_mac_first !== e.first || o_out_idx !== 7'(e.idx)) begin
                        n_fail++;
                        $display("FAIL mac_beat: got addr=%0d first=%0b idx=%0d, required addr=%0d first=%0b idx=%0d",
                                 o_w_addr, o_mac_first, o_out_idx, e.addr, e.first, e.idx);
                    end
                end
            end
            if (o_neuron_commit) begin
                n_commit++;
                n_tests++;
                if (exp_commit_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL commit_unexpected: got commit idx %0d, required none", o_out_idx);
                end else begin
                    c = exp_commit_q.pop_front();
                    if (o_out_idx !== 7'(c)) begin
                        n_fail++;
                        $display("FAIL commit_idx: got %0d, required %0d", o_out_idx, c);
                    end
                end
            end
            if (o_layer_1_done || o_layer_2_done || o_layer_3_done) begin
                lay = o_layer_1_done ? 1 : (o_layer_2_done ? 2 : 3);
                n_done[lay]++;
                n_tests++;
                if (exp_done_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_unexpected: got layer %0d done, required none", lay);
                end else begin
                    d = exp_done_q.pop_front();
                    if (lay != d || (32'(o_layer_1_done) + 32'(o_layer_2_done) + 32'(o_layer_3_done)) != 1) begin
                        n_fail++;
                        $display("FAIL done_layer: got done bits %0b%0b%0b, required only layer %0d",
                                 o_layer_3_done, o_layer_2_done, o_layer_1_done, d);
                    end
                end
            end
            if (o_w_req && prev_req && !prev_valid) begin
                n_tests++;
                if (o_w_addr !== prev_addr) begin
                    n_fail++;
                    $display("FAIL addr_stable: got %0d, required %0d", o_w_addr, prev_addr);
                end
            end
            if (o_w_req) begin
                if (req_wait >= resp_delay) begin
                    w_valid = 1'b1;
                    req_wait = 0;
                end else begin
                    w_valid = 1'b0;
                    req_wait++;
                end
            end else begin
                w_valid = valid_force;
                req_wait = 0;
            end
            prev_req   = o_w_req;
            prev_valid = w_valid;
            prev_addr  = o_w_addr;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        state = 3'b000;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (all_outs !== 26'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h, required 0", all_outs);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (o_w_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_req: got %0b, required 0", o_w_req);
        end
    endtask

    task automatic test_l1_full();
        int m0 = n_mac;
        int c0 = n_commit;
        int cyc = 0;
        bit seen = 1'b0;
        resp_delay = 0;
        push_layer(1);
        state = 3'b010;
        while (!seen && cyc < 10000) begin
            @(negedge clk);
            cyc++;
            if (o_layer_1_done) seen = 1'b1;
        end
        n_tests++;
        if (!seen || cyc != 128 * (2 * 25 + 1) + 1) begin
            n_fail++;
            $display("FAIL l1_done_cycle: got seen=%0b cycle=%0d, required cycle %0d", seen, cyc, 128 * 51 + 1);
        end
        n_tests++;
        if (n_mac - m0 != 3200 || n_commit - c0 != 128) begin
            n_fail++;
            $display("FAIL l1_counts: got mac=%0d commit=%0d, required 3200/128", n_mac - m0, n_commit - c0);
        end
        @(negedge clk);
        n_tests++;
        if (exp_mac_q.size() != 0 || exp_commit_q.size() != 0 || exp_done_q.size() != 0) begin
            n_fail++;
            $display("FAIL l1_leftover: got %0d/%0d/%0d pending, required 0", exp_mac_q.size(), exp_commit_q.size(), exp_done_q.size());
        end
    endtask

    task automatic test_hold_no_rerun();
        repeat (20) begin
            @(negedge clk);
            n_tests++;
            if (o_w_req !== 1'b0 || o_mac_en !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_no_rerun: got req=%0b mac=%0b, required 0/0", o_w_req, o_mac_en);
            end
        end
    endtask

    task automatic test_l2_stalled();
        int m0 = n_mac;
        int c0 = n_commit;
        int cyc = 0;
        bit found = 1'b0;
        bit seen = 1'b0;
        push_layer(2);
        resp_delay = 3;
        state = 3'b011;
        for (int k = 0; k < 2 && !found; k++) begin
            @(negedge clk);
            if (o_w_req) found = 1'b1;
        end
        n_tests++;
        if (!found || o_w_addr !== 12'd3200) begin
            n_fail++;
            $display("FAIL l2_start: got req=%0b addr=%0d, required 1/3200", found, o_w_addr);
        end
        while (!seen && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (o_layer_2_done) seen = 1'b1;
        end
        n_tests++;
        if (!seen || n_mac - m0 != 256 || n_commit - c0 != 64) begin
            n_fail++;
            $display("FAIL l2_run: got done=%0b mac=%0d commit=%0d, required 1/256/64", seen, n_mac - m0, n_commit - c0);
        end
`ifdef BNN_SEQ_PERF_EN
        n_tests++;
        if (o_perf_stall_cnt !== 32'd768) begin
            n_fail++;
            $display("FAIL l2_perf_stall: got %0d, required 768", o_perf_stall_cnt);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_l3();
        int m0 = n_mac;
        int c0 = n_commit;
        int d0 = n_done[3];
        int cyc = 0;
        bit seen = 1'b0;
        push_layer(3);
        resp_delay = 1;
        state = 3'b100;
        while (!seen && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (o_layer_3_done) seen = 1'b1;
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if (!seen || n_done[3] - d0 != 1 || n_mac - m0 != 20 || n_commit - c0 != 10) begin
            n_fail++;
            $display("FAIL l3_run: got done=%0b pulses=%0d mac=%0d commit=%0d, required 1/1/20/10",
                     seen, n_done[3] - d0, n_mac - m0, n_commit - c0);
        end
        n_tests++;
        if (exp_mac_q.size() != 0 || exp_done_q.size() != 0) begin
            n_fail++;
            $display("FAIL l3_leftover: got %0d/%0d pending, required 0", exp_mac_q.size(), exp_done_q.size());
        end
    endtask

    task automatic test_abort();
        int m0;
        int cyc = 0;
        bit found = 1'b0;
        int d0 = n_done[1];
        state = 3'b000;
        repeat (3) @(negedge clk);
        push_layer(1);
        resp_delay = 3;
        m0 = n_mac;
        state = 3'b010;
        while (n_mac - m0 < 7 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (o_w_req) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL abort_setup: got no request in window, required w_req=1");
        end
        state = 3'b000;
        flush_expect();
        @(negedge clk);
        n_tests++;
        if (o_w_req !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_req_drop: got %0b, required 0", o_w_req);
        end
        valid_force = 1'b1;
        repeat (6) begin
            @(negedge clk);
            n_tests++;
            if (o_mac_en !== 1'b0 || o_w_req !== 1'b0 || o_neuron_commit !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_late_valid: got mac=%0b req=%0b commit=%0b, required 0/0/0",
                         o_mac_en, o_w_req, o_neuron_commit);
            end
        end
        valid_force = 1'b0;
        n_tests++;
        if (n_done[1] != d0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done pulses, required 0", n_done[1] - d0);
        end
    endtask

    task automatic test_async_reset();
        int cyc = 0;
        bit found = 1'b0;
        bit seen = 1'b0;
        push_layer(1);
        resp_delay = 0;
        state = 3'b010;
        while (!found && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (o_mac_en && o_out_idx == 7'd5) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL areset_setup: got no ACC of neuron 5, required one");
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (all_outs !== 26'd0) begin
            n_fail++;
            $display("FAIL areset_immediate: got %h, required 0", all_outs);
        end
        flush_expect();
        push_layer(1);
        @(negedge clk);
        n_tests++;
        if (all_outs !== 26'd0) begin
            n_fail++;
            $display("FAIL areset_held: got %h, required 0", all_outs);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (o_w_req !== 1'b1 || o_w_addr !== 12'd0 || o_out_idx !== 7'd0) begin
            n_fail++;
            $display("FAIL areset_restart: got req=%0b addr=%0d idx=%0d, required 1/0/0", o_w_req, o_w_addr, o_out_idx);
        end
        cyc = 0;
        while (!seen && cyc < 10000) begin
            @(negedge clk);
            cyc++;
            if (o_layer_1_done) seen = 1'b1;
        end
        @(negedge clk);
        n_tests++;
        if (!seen || exp_mac_q.size() != 0 || exp_done_q.size() != 0) begin
            n_fail++;
            $display("FAIL areset_rerun: got done=%0b pending=%0d, required 1/0", seen, exp_mac_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_l1_full();
        test_hold_no_rerun();
        test_l2_stalled();
        test_l3();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
